// File: rtl/dec_lut_encoder8bits_clk_if.sv
// Request/codeword bus between the triangular-codeword encoder and its neighbours.
// master: requester and decoder side; slave: the encoder.
interface dec_lut_encoder8bits_clk_if #(
    parameter int unsigned N_BITS = 9,
    parameter int unsigned W_BITS = 20
);
    logic              start;
    logic [N_BITS-1:0] N_in;
    logic              ready;
    logic [W_BITS-1:0] W;
    logic              W_valid;
    logic              found;
    logic              timeout;
    logic              busy;

    modport master (
        output start, N_in, found,
        input  ready, W, W_valid, timeout, busy
    );

    modport slave (
        input  start, N_in, found,
        output ready, W, W_valid, timeout, busy
    );
endinterface

// File: rtl/dec_lut_encoder8bits_clk.sv
// Iterative shift-add encoder producing W = N*(N+1)/2, held on the bus until
// the downstream decoder acknowledges with found or the hold timeout expires.
module dec_lut_encoder8bits_clk #(
    parameter int unsigned W_BITS  = 20,
    parameter int unsigned N_BITS  = 9,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    dec_lut_encoder8bits_clk_if.slave    bus
);

    localparam int unsigned ACC_W = W_BITS + 1;
    localparam int unsigned MC_W  = N_BITS + 1;
    localparam int unsigned CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int unsigned HC_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N_BITS - 1);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [MC_W-1:0]   mcand;
    logic [N_BITS-1:0] mplier;
    logic [CNT_W-1:0]  cnt;
    logic [HC_W-1:0]   hold_cnt;

    logic              ready_q;
    logic              busy_q;
    logic [W_BITS-1:0] w_q;
    logic              w_valid_q;
    logic              timeout_q;

    logic [ACC_W-1:0]  addend;
    logic [ACC_W-1:0]  acc_next;

    // Partial product for the current multiplier bit, kept at full accumulator width.
    always_comb begin
        addend   = '0;
        if (mplier[cnt]) begin
            addend = ACC_W'(mcand) << cnt;
        end
        acc_next = acc + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            hold_cnt  <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            w_q       <= '0;
            w_valid_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mplier  <= bus.N_in;
                        mcand   <= {1'b0, bus.N_in} + {{N_BITS{1'b0}}, 1'b1};
                        acc     <= '0;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= CALC;
                    end
                end

                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        // Product N*(N+1) is always even, so the shift is exact.
                        w_q       <= W_BITS'(acc_next >> 1);
                        w_valid_q <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= HOLD;
                    end
                end

                HOLD: begin
                    if (bus.found) begin
                        w_valid_q <= 1'b0;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end else if ((TIMEOUT > 0) && (hold_cnt == HOLD_LAST)) begin
                        w_valid_q <= 1'b0;
                        timeout_q <= 1'b1;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end else if (TIMEOUT > 0) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end

                default: begin
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    w_valid_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.busy    = busy_q;
    assign bus.W       = w_q;
    assign bus.W_valid = w_valid_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_dec_lut_encoder8bits_clk.sv
// Scoreboard bench for the triangular-codeword encoder with a behavioural
// decoder acknowledging through found.
module tb_dec_lut_encoder8bits_clk;

    localparam int unsigned N_BITS  = 9;
    localparam int unsigned W_BITS  = 20;
    localparam int unsigned TIMEOUT = 64;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;
    int to_cnt = 0;
    int exp_q[$];

    dec_lut_encoder8bits_clk_if #(.N_BITS(N_BITS), .W_BITS(W_BITS)) bus ();

    dec_lut_encoder8bits_clk #(
        .W_BITS (W_BITS),
        .N_BITS (N_BITS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    function automatic int tri_inv(input int w);
        for (int i = 0; i < 1024; i++) begin
            if (i * (i + 1) / 2 == w) return i;
        end
        return -1;
    endfunction

    // Monitor: every rising W_valid consumes one expected codeword.
    initial begin
        logic prev;
        int   e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.W_valid === 1'b1 && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected W_valid W=%0d expected none", bus.W);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_W", 32'(bus.W), e);
                end
            end
            if (bus.timeout === 1'b1) to_cnt++;
            prev = (bus.W_valid === 1'b1);
        end
    end

    task automatic launch(input int n, input int exp_w, input bit poke_calc, input bit push);
        int k;
        k = 0;
        while (bus.ready !== 1'b1 && k < 100) begin
            @(posedge clk); #1; k++;
        end
        chk("ready_before_start", 32'(bus.ready), 1);
        if (push) exp_q.push_back(exp_w);
        bus.N_in  = N_BITS'(n);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_accept", {30'd0, bus.busy, bus.ready}, 2);
        k = 0;
        while (bus.W_valid !== 1'b1 && k < 30) begin
            @(posedge clk); #1; k++;
            if (poke_calc && k == 3) begin
                bus.N_in  = 7;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("w_valid_latency", k, N_BITS);
    endtask

    task automatic encode(input int n, input int exp_w, input int found_delay,
                          input bit poke_calc, input bit start_with_found, output int w_seen);
        launch(n, exp_w, poke_calc, 1'b1);
        w_seen = int'(bus.W);
        repeat (found_delay) begin
            @(posedge clk); #1;
            chk("W_stable", 32'(bus.W), exp_w);
        end
        bus.found = 1'b1;
        if (start_with_found) begin
            bus.start = 1'b1;
            bus.N_in  = 3;
        end
        @(posedge clk); #1;
        bus.found = 1'b0;
        bus.start = 1'b0;
        chk("release_valid_ready_timeout", {29'd0, bus.W_valid, bus.ready, bus.timeout}, 3'b010);
        chk("W_kept", 32'(bus.W), exp_w);
        if (start_with_found) begin
            @(posedge clk); #1;
            chk("start_dropped", {30'd0, bus.busy, bus.ready}, 1);
        end
    endtask

    task automatic encode_timeout(input int n, input int exp_w);
        launch(n, exp_w, 1'b0, 1'b1);
        repeat (TIMEOUT - 1) begin
            @(posedge clk); #1;
        end
        chk("no_early_timeout", {30'd0, bus.W_valid, bus.timeout}, 2'b10);
        @(posedge clk); #1;
        chk("timeout_fire", {29'd0, bus.W_valid, bus.ready, bus.timeout}, 3'b011);
        @(posedge clk); #1;
        chk("timeout_one_cycle", 32'(bus.timeout), 0);
    endtask

    initial begin
        int ws;
        bus.start = 1'b0;
        bus.found = 1'b0;
        bus.N_in  = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_W", 32'(bus.W), 0);
        chk("rst_W_valid", 32'(bus.W_valid), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        encode(255, 32640, 5, 1'b0, 1'b0, ws);
        encode(0, 0, 1, 1'b0, 1'b0, ws);
        encode(511, 130816, 2, 1'b0, 1'b0, ws);
        encode(1, 1, 0, 1'b0, 1'b0, ws);
        encode(100, 5050, 3, 1'b1, 1'b0, ws);
        encode(200, 20100, 2, 1'b0, 1'b1, ws);
        encode_timeout(50, 1275);
        encode(63, 2016, TIMEOUT - 1, 1'b0, 1'b0, ws);

        // Reset pulse while cnt=4 in CALC; result must never appear.
        launch_abort();
        encode(10, 55, 1, 1'b0, 1'b0, ws);

        for (int n = 0; n < 512; n++) begin
            encode(n, n * (n + 1) / 2, n % 4, 1'b0, 1'b0, ws);
            chk("roundtrip_N", tri_inv(ws), n);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("timeout_pulse_count", to_cnt, 1);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic launch_abort();
        int k;
        k = 0;
        while (bus.ready !== 1'b1 && k < 100) begin
            @(posedge clk); #1; k++;
        end
        bus.N_in  = 20;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.ready), 1);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_W", 32'(bus.W), 0);
        chk("abort_W_valid", 32'(bus.W_valid), 0);
        #1.5 rst_n = 1'b1;
        k = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.W_valid === 1'b1) k++;
        end
        chk("abort_no_w_valid", k, 0);
        chk("abort_idle", {30'd0, bus.busy, bus.ready}, 1);
    endtask

endmodule
